// File: rtl/pkg_ram.sv
// Shared RAM geometry constants, load-size encoding and load FSM states.
package pkg_ram;

   localparam int RAM_DATA_BYTES = 4;
   localparam int RAM_ADDR_W     = 16;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      WORD = 2'd1,
      LONG = 2'd2,
      QUAD = 2'd3
   } load_size_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      FILL,
      RESP
   } state_t;

endpackage

// File: rtl/ram_byte_shift.sv
// Combinational right shift of a byte vector by a whole number of bytes,
// returning only the low OUT_BYTES bytes of the result.
module ram_byte_shift #(
   parameter int IN_BYTES  = 8,
   parameter int OUT_BYTES = 4,
   parameter int SHIFT_W   = $clog2(IN_BYTES)
) (
   input  logic [8*IN_BYTES-1:0]  din,
   input  logic [SHIFT_W-1:0]     shift,
   output logic [8*OUT_BYTES-1:0] dout
);

   localparam int OUT_W = 8 * OUT_BYTES;

   // Byte offset becomes a bit shift by appending three zero bits.
   always_comb begin
      dout = OUT_W'(din >> {shift, 3'b000});
   end

endmodule

// File: rtl/ram_load_align.sv
// Unaligned load unit: reads one or two RAM longs, extracts the addressed
// field and returns it zero- or sign-extended to a full long.
module ram_load_align
   import pkg_ram::*;
#(
   parameter int DATA_BYTES = RAM_DATA_BYTES,
   parameter int ADDR_W     = RAM_ADDR_W
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic [ADDR_W-1:0]                      req_addr,
   input  logic [1:0]                             req_size,
   input  logic                                   req_signed,
   output logic                                   ram_rd_en,
   output logic [ADDR_W-$clog2(DATA_BYTES)-1:0]   ram_addr,
   input  logic [8*DATA_BYTES-1:0]                ram_rd_data,
   output logic                                   rsp_valid,
   input  logic                                   rsp_ready,
   output logic [8*DATA_BYTES-1:0]                rsp_data
);

   localparam int LOG_DB = $clog2(DATA_BYTES);
   localparam int IDX_W  = ADDR_W - LOG_DB;
   localparam int DW     = 8 * DATA_BYTES;

   state_t             state;
   state_t             state_next;
   logic               run_q;
   logic [ADDR_W-1:0]  addr_q;
   load_size_t         size_q;
   logic               signed_q;
   logic [DW-1:0]      lo_data_q;
   logic [DW-1:0]      rsp_data_q;

   logic [LOG_DB-1:0]  offset;
   logic [IDX_W-1:0]   lo_idx;
   int                 width_bytes;
   logic               span;
   load_size_t         size_clamped;
   logic [2*DW-1:0]    window;
   logic [DW-1:0]      field;
   logic [DW-1:0]      extended;
   logic               sign_bit;

   assign offset    = addr_q[LOG_DB-1:0];
   assign lo_idx    = addr_q[ADDR_W-1:LOG_DB];
   assign req_ready = run_q && (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_data  = rsp_data_q;

   // Width in bytes of the registered access and whether it crosses into the next long.
   always_comb begin
      width_bytes = 1 << int'(size_q);
      span        = (int'(offset) + width_bytes) > DATA_BYTES;
   end

   // Requests wider than one long are treated as full-long loads.
   always_comb begin
      if (int'(req_size) > LOG_DB) begin
         size_clamped = load_size_t'(LOG_DB[1:0]);
      end else begin
         size_clamped = load_size_t'(req_size);
      end
   end

   // Two-long window {hi,lo}; hi is zero when the field sits inside one long.
   always_comb begin
      if (span) begin
         window = {ram_rd_data, lo_data_q};
      end else begin
         window = {{DW{1'b0}}, ram_rd_data};
      end
   end

   ram_byte_shift #(
      .IN_BYTES  (2 * DATA_BYTES),
      .OUT_BYTES (DATA_BYTES)
   ) u_shift (
      .din   (window),
      .shift ({1'b0, offset}),
      .dout  (field)
   );

   // Keep the low width bytes and fill the rest with zeros or the field's top bit.
   always_comb begin
      sign_bit = 1'b0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i == width_bytes - 1) begin
            sign_bit = field[8*i+7];
         end
      end
      extended = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i < width_bytes) begin
            extended[8*i +: 8] = field[8*i +: 8];
         end else begin
            extended[8*i +: 8] = {8{signed_q & sign_bit}};
         end
      end
   end

   // Next-state logic and RAM read strobes.
   always_comb begin
      state_next = state;
      ram_rd_en  = 1'b0;
      ram_addr   = lo_idx;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_next = RD_LO;
            end
         end
         RD_LO: begin
            ram_rd_en  = 1'b1;
            ram_addr   = lo_idx;
            state_next = span ? RD_HI : FILL;
         end
         RD_HI: begin
            ram_rd_en  = 1'b1;
            ram_addr   = lo_idx + IDX_W'(1);
            state_next = FILL;
         end
         FILL: begin
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Holds req_ready low until the first clock edge after reset releases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // Request capture, low-long capture and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         size_q     <= BYTE;
         signed_q   <= 1'b0;
         lo_data_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         if (req_valid && req_ready) begin
            addr_q   <= req_addr;
            size_q   <= size_clamped;
            signed_q <= req_signed;
         end
         if (state == RD_HI) begin
            lo_data_q <= ram_rd_data;
         end
         if (state == FILL) begin
            rsp_data_q <= extended;
         end
      end
   end

endmodule
